// File: rtl/arb_demux_d_pkg.sv
// Shared types and defaults for the two-VC arbiter / destination demux.
package arb_demux_d_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    localparam int DATA_SIZE_DEF = 6;
    localparam int DEST_BIT_DEF  = 4;
    localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/arb_demux_d_route_stage.sv
// Two-stage read pipeline: s1 tracks the pop source, s2 decodes the destination and pushes.
// Pop to push is 2 cycles; it never stalls, so in-flight words always land regardless of pause.
module arb_demux_d_route_stage
    import arb_demux_d_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int DEST_BIT  = DEST_BIT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 pop_vc0,
    input  logic                 pop_vc1,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    output logic                 s1_valid,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1
);

    logic                 s1_src;
    logic [DATA_SIZE-1:0] word;
    logic                 dest;

    // The VC FIFOs present registered read data one cycle after the pop.
    assign word = s1_src ? vc1_data : vc0_data;
    assign dest = word[DEST_BIT];

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            s1_valid <= 1'b0;
            s1_src   <= 1'b0;
            push_d0  <= 1'b0;
            push_d1  <= 1'b0;
            data_d0  <= '0;
            data_d1  <= '0;
            cnt_d0   <= '0;
            cnt_d1   <= '0;
        end else begin
            s1_valid <= pop_vc0 | pop_vc1;
            s1_src   <= pop_vc1;
            push_d0  <= s1_valid && (dest == DEST_D0);
            push_d1  <= s1_valid && (dest == DEST_D1);
            if (s1_valid) begin
                if (dest == DEST_D1) begin
                    data_d1 <= word;
                end else begin
                    data_d0 <= word;
                end
            end
            if (push_d0) begin
                cnt_d0 <= cnt_d0 + CNT_W'(1);
            end
            if (push_d1) begin
                cnt_d1 <= cnt_d1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/arb_demux_d.sv
// Strict-priority (vc0 first) arbiter feeding a destination demux; pop to push is 2 cycles.
// Pops stop the same cycle either destination pauses; up to 2 in-flight words still drain.
module arb_demux_d
    import arb_demux_d_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int DEST_BIT  = DEST_BIT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1,
    output logic                 active
);

    state_t state;
    logic   go;
    logic   pop_any;
    logic   s1_valid;

    // Destination is unknown until the word is read, so either pause blocks all pops.
    assign go      = reset_L & ~pause_d0 & ~pause_d1;
    assign pop_vc0 = go & ~vc0_empty;
    assign pop_vc1 = go & vc0_empty & ~vc1_empty;
    assign pop_any = pop_vc0 | pop_vc1;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (pop_any) state <= BUSY;
                BUSY:    if (!pop_any && !s1_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign active = (state == BUSY) | s1_valid | push_d0 | push_d1;

    arb_demux_d_route_stage #(
        .DATA_SIZE (DATA_SIZE),
        .DEST_BIT  (DEST_BIT),
        .CNT_W     (CNT_W)
    ) u_route (
        .clk      (clk),
        .reset_L  (reset_L),
        .pop_vc0  (pop_vc0),
        .pop_vc1  (pop_vc1),
        .vc0_data (vc0_data),
        .vc1_data (vc1_data),
        .s1_valid (s1_valid),
        .push_d0  (push_d0),
        .push_d1  (push_d1),
        .data_d0  (data_d0),
        .data_d1  (data_d1),
        .cnt_d0   (cnt_d0),
        .cnt_d1   (cnt_d1)
    );

endmodule

// File: tb/tb_arb_demux_d.sv
// Directed bench with a push scoreboard; VC FIFOs are modelled as queues with registered read data.
module tb_arb_demux_d;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       vc0_empty = 1'b1;
    logic       vc1_empty = 1'b1;
    logic [5:0] vc0_data = '0;
    logic [5:0] vc1_data = '0;
    logic       pause_d0 = 1'b0;
    logic       pause_d1 = 1'b0;
    logic       pop_vc0, pop_vc1, push_d0, push_d1, active;
    logic [5:0] data_d0, data_d1;
    logic [7:0] cnt_d0, cnt_d1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] p0[$];
    logic [5:0] p1[$];
    logic [6:0] exp_q[$];
    int         lat_q[$];

    always #5 clk = ~clk;

    arb_demux_d dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .vc0_data  (vc0_data),
        .vc1_data  (vc1_data),
        .pause_d0  (pause_d0),
        .pause_d1  (pause_d1),
        .pop_vc0   (pop_vc0),
        .pop_vc1   (pop_vc1),
        .push_d0   (push_d0),
        .push_d1   (push_d1),
        .data_d0   (data_d0),
        .data_d1   (data_d1),
        .cnt_d0    (cnt_d0),
        .cnt_d1    (cnt_d1),
        .active    (active)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // VC FIFO model: pops update read data on the edge, loads become visible after the next edge.
    initial begin : vc_model
        logic [5:0] w;
        forever begin
            @(posedge clk);
            if (pop_vc0 || pop_vc1) begin
                chk("pop_exclusive", int'(pop_vc0 && pop_vc1), 0);
                lat_q.push_back(cyc);
            end
            if (pop_vc0) begin
                chk("pop_vc0_nonempty", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    w = q0.pop_front();
                    vc0_data <= w;
                end
            end
            if (pop_vc1) begin
                chk("pop_vc1_nonempty", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    w = q1.pop_front();
                    vc1_data <= w;
                end
            end
            if (!reset_L) lat_q.delete();
            while (p0.size() > 0) q0.push_back(p0.pop_front());
            while (p1.size() > 0) q1.push_back(p1.pop_front());
            vc0_empty <= (q0.size() == 0);
            vc1_empty <= (q1.size() == 0);
            cyc++;
        end
    end

    // Scoreboard monitor: every push must match the next hand-computed {dest, data} entry.
    initial begin : monitor
        logic [6:0] e;
        int         pc;
        forever begin
            @(negedge clk);
            if (push_d0 || push_d1) begin
                chk("push_exclusive", int'(push_d0 && push_d1), 0);
                chk("push_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("push_dest", int'(push_d1), int'(e[6]));
                    chk("push_data", int'(push_d1 ? data_d1 : data_d0), int'(e[5:0]));
                end
                pc = (lat_q.size() > 0) ? lat_q.pop_front() : cyc + 100;
                chk("push_latency", cyc - pc, 2);
            end
        end
    end

    logic [5:0] pr0[3] = '{6'b000001, 6'b010010, 6'b000011};
    logic [5:0] pr1[2] = '{6'b110100, 6'b001101};
    logic [6:0] pr_exp[5] = '{7'b0_000001, 7'b1_010010, 7'b0_000011, 7'b1_110100, 7'b0_001101};
    logic       pr_pop0[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       pr_pop1[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] pz[6] = '{6'b000101, 6'b011110, 6'b100111, 6'b111000, 6'b001001, 6'b010000};
    logic [6:0] pz_exp[6] = '{7'b0_000101, 7'b1_011110, 7'b0_100111, 7'b1_111000, 7'b0_001001, 7'b1_010000};

    initial begin : stimulus
        // Reset held with vc0 non-empty
        p0.push_back(6'b010011);
        exp_q.push_back({1'b1, 6'b010011});
        repeat (2) step();
        chk("rst_vc0_loaded", int'(vc0_empty), 0);
        chk("rst_pop_vc0", int'(pop_vc0), 0);
        chk("rst_push_d0", int'(push_d0), 0);
        chk("rst_push_d1", int'(push_d1), 0);
        chk("rst_cnt_d0", int'(cnt_d0), 0);
        chk("rst_cnt_d1", int'(cnt_d1), 0);
        chk("rst_active", int'(active), 0);

        // Single word to d1, then the empty boundary and active fall
        step();
        reset_L = 1'b1;
        #1;
        chk("single_pop", int'(pop_vc0), 1);
        step();
        chk("single_no_pop_empty", int'(pop_vc0 | pop_vc1), 0);
        chk("single_active_t1", int'(active), 1);
        step();
        chk("single_active_t2", int'(active), 1);
        chk("single_push_d1", int'(push_d1), 1);
        chk("single_push_d0", int'(push_d0), 0);
        step();
        chk("single_active_t3", int'(active), 0);
        chk("single_cnt_d1", int'(cnt_d1), 1);
        chk("single_cnt_d0", int'(cnt_d0), 0);

        // Strict priority: three vc0 words before any vc1 word
        step();
        for (int i = 0; i < 3; i++) p0.push_back(pr0[i]);
        for (int i = 0; i < 2; i++) p1.push_back(pr1[i]);
        for (int i = 0; i < 5; i++) exp_q.push_back(pr_exp[i]);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("prio_pop_vc0", int'(pop_vc0), int'(pr_pop0[i]));
            chk("prio_pop_vc1", int'(pop_vc1), int'(pr_pop1[i]));
        end
        repeat (4) step();

        // Pause mid-stream: two in-flight words still land, then pops resume
        step();
        for (int i = 0; i < 6; i++) p0.push_back(pz[i]);
        for (int i = 0; i < 6; i++) exp_q.push_back(pz_exp[i]);
        step();
        chk("pause_pop_a", int'(pop_vc0), 1);
        step();
        chk("pause_pop_b", int'(pop_vc0), 1);
        step();
        pause_d0 = 1'b1;
        #1;
        chk("pause_pop_stop", int'(pop_vc0 | pop_vc1), 0);
        step();
        step();
        chk("pause_drained", int'(push_d0 | push_d1), 0);
        chk("pause_still_stopped", int'(pop_vc0 | pop_vc1), 0);
        step();
        pause_d0 = 1'b0;
        #1;
        chk("pause_resume", int'(pop_vc0), 1);
        repeat (8) step();
        chk("total_cnt_d0", int'(cnt_d0), 6);
        chk("total_cnt_d1", int'(cnt_d1), 6);

        // pause_d1 also blocks pops
        step();
        pause_d1 = 1'b1;
        p1.push_back(6'b001111);
        exp_q.push_back({1'b0, 6'b001111});
        step();
        chk("pause_d1_block", int'(pop_vc1), 0);
        step();
        pause_d1 = 1'b0;
        #1;
        chk("pause_d1_resume", int'(pop_vc1), 1);
        repeat (4) step();
        chk("after_pd1_cnt_d0", int'(cnt_d0), 7);

        // Reset the cycle after a pop: the word is dropped
        step();
        p0.push_back(6'b000110);
        step();
        chk("mid_pop", int'(pop_vc0), 1);
        step();
        reset_L = 1'b0;
        #1;
        chk("mid_rst_pop_forced", int'(pop_vc0 | pop_vc1), 0);
        step();
        reset_L = 1'b1;
        #1;
        chk("mid_no_push", int'(push_d0 | push_d1), 0);
        repeat (3) step();
        chk("mid_cnt_d0", int'(cnt_d0), 0);
        chk("mid_cnt_d1", int'(cnt_d1), 0);
        chk("mid_active", int'(active), 0);
        chk("exp_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_demux_d.md
Name: arb_demux_d

Overview:
- Upstream neighbour of the destination FIFOs fifo_d0 and fifo_d1.
- Arbitrates between two virtual-channel FIFOs (vc0, vc1) using strict priority to vc0.
- Pops one word per cycle, reads the destination bit of each word, and pushes the word into fifo_d0 or fifo_d1.
- Stops issuing pops while either destination FIFO asserts pause. Words already in flight still drain.

Parameters:
- DATA_SIZE, 6, word width; matches the VC and destination FIFOs.
- DEST_BIT, 4, bit index of the destination select: 0 routes to d0, 1 routes to d1.
- CNT_W, 8, width of the per-destination delivered-word counters.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_L  in  1  synchronous, active-low reset.
- vc0_empty  in  1  empty flag of VC0 FIFO.
- vc1_empty  in  1  empty flag of VC1 FIFO.
- vc0_data  in  DATA_SIZE  VC0 FIFO registered read data; valid the cycle after pop_vc0.
- vc1_data  in  DATA_SIZE  VC1 FIFO registered read data; valid the cycle after pop_vc1.
- pause_d0  in  1  fifo_pause_d0 from fifo_d0.
- pause_d1  in  1  fifo_pause_d1 from fifo_d1.
- pop_vc0  out  1  pop strobe to VC0; combinational.
- pop_vc1  out  1  pop strobe to VC1; combinational.
- push_d0  out  1  push strobe to fifo_d0; registered.
- push_d1  out  1  push strobe to fifo_d1; registered.
- data_d0  out  DATA_SIZE  word to fifo_d0; registered.
- data_d1  out  DATA_SIZE  word to fifo_d1; registered.
- cnt_d0  out  CNT_W  words delivered to d0; wraps.
- cnt_d1  out  CNT_W  words delivered to d1; wraps.
- active  out  1  high while in state BUSY or any pipeline stage is valid.

Behaviour:
- Reset, sampled while reset_L=0 at a clk edge: all outputs 0, state IDLE, pipeline valid bits 0.
  - pop_vc0 and pop_vc1 are forced to 0 combinationally while reset_L=0.
- Pop enable: go = reset_L & !pause_d0 & !pause_d1.
  - Both pauses are checked because the destination is unknown before the read.
- Arbitration, combinational:
  - pop_vc0 = go & !vc0_empty.
  - pop_vc1 = go & vc0_empty & !vc1_empty.
  - Never both high. Never pop an empty FIFO.
- FSM, two states; transitions are evaluated each edge with reset_L=1:
  - IDLE moves to BUSY when a pop issues.
  - BUSY moves to IDLE when no pop issues this cycle and stage s1 is empty.
  - active = (state==BUSY) | s1_valid | push_d0 | push_d1.
- Pipeline, two stages:
  - Stage s1: on the edge ending pop cycle t, s1_valid<=pop_vc0|pop_vc1 and s1_src<=pop_vc1.
  - Stage s2: on the edge ending cycle t+1, if s1_valid, word w = s1_src ? vc1_data : vc0_data.
    - push_d0<=!w[DEST_BIT]; push_d1<=w[DEST_BIT].
    - The selected data_dX<=w; the other data bus holds its value.
  - If !s1_valid at that edge, both push strobes go to 0.
  - Latency from pop to push = 2 cycles. Throughput is 1 word per cycle, back-to-back.
- Counters:
  - cnt_dX increments on each edge where push_dX is 1.
  - Wraps from 2^CNT_W-1 to 0.
- Pause mid-stream:
  - Pops stop in the same cycle pause rises.
  - At most 2 words are still in flight; they are delivered regardless of pause.
  - The destination FIFO afd threshold must leave at least 2 entries of slack.
- Pause deassert: pops resume in the same cycle.
- vc0 refilling while vc1 is being served: vc0 wins on the next cycle. No fairness is provided.
- Reset mid-operation:
  - In-flight words are dropped and are not pushed.
  - The upstream FIFOs are reset by the same reset_L.
- Bits of w other than DEST_BIT pass through unchanged. No word is modified.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1;
  - DEST_D0=1'b0 and DEST_D1=1'b1;
  - default DATA_SIZE and DEST_BIT.
- One natural sub-module: route_stage.
  - It implements the s1-to-s2 registers, the destination decode, and both counters.
  - The top level keeps the arbitration and the FSM.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with vc0 non-empty -> pops=0, pushes=0, cnt_d0=cnt_d1=0, active=0.
- Single word: vc0 holds 6'b010011 (bit4=1) and is popped at cycle t -> push_d1=1 with data_d1=6'b010011 at t+2, cnt_d1=1, push_d0 stays 0.
- Priority: both VCs non-empty, vc0 holds 3 words -> pop_vc0 for 3 consecutive cycles, then pop_vc1. Pushes keep the same order, 2 cycles delayed.
- Pause: pause_d0 rises during a back-to-back stream -> pops=0 the same cycle. Exactly the 2 in-flight words are still pushed, then pushes=0. Pops resume the cycle pause drops.
- Empty boundary: vc0 holds 1 word, vc1 is empty -> exactly one pop_vc0 and no pop while empty. FSM goes BUSY then IDLE; active falls 3 cycles after the pop.
- Reset mid-flight: reset_L=0 in the cycle after a pop -> no push occurs, counters read 0 after release.
